ibr128_block_ctrl: RTL and testbench

//  Initiator-side sequencer for the IBR128 encrypt core. Accepts 128-bit blocks on a

---
 rtl/ibr128_block_ctrl_pkg.sv | 16 +
 rtl/ibr128_block_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ibr128_block_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibr128_block_ctrl_pkg.sv
// Shared types for the IBR128 block sequencer: block width and FSM state encoding.
package ibr128_block_ctrl_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/ibr128_block_ctrl.sv
// Initiator-side sequencer for the IBR128 core: stream in, one core operation with
// optional CBC chaining in either direction, stream out, with a completion timeout.
module ibr128_block_ctrl
  import ibr128_block_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         cfg_encrypt,
  input  logic         cfg_sa,
  input  logic         cfg_cbc,
  input  logic         iv_load,
  input  logic [127:0] iv_data,
  input  logic         clr_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         encrypt,
  output logic         sa,
  output logic         block_start,
  output logic [127:0] pData,
  input  logic         block_ready,
  input  logic [127:0] eData,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err_timeout
);

  state_e          state_q, state_d;
  logic            enc_q, enc_d, sa_q, sa_d, cbc_q, cbc_d;
  block_t          in_reg_q, in_reg_d, pdata_q, pdata_d;
  block_t          chain_q, chain_d, out_data_q, out_data_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d, start_q, start_d;
  logic            out_valid_q, out_valid_d, busy_q, busy_d;
  logic            to_hit;
  block_t          chain_src;

  always_comb begin
    // NOTE: every _d starts from its _q (hold) so no branch below can infer a latch.
    state_d    = state_q;
    enc_d      = enc_q;
    sa_d       = sa_q;
    cbc_d      = cbc_q;
    in_reg_d   = in_reg_q;
    pdata_d    = pdata_q;
    chain_d    = chain_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + TO_W'(1);
    to_hit     = (cnt_inc == TO_W'(TIMEOUT_CYCLES));
    // A same-cycle IV load takes effect before the accepted block is chained.
    chain_src  = iv_load ? iv_data : chain_q;
    // Timeout is applied after the clear, so a coincident timeout keeps the flag set.
    err_d      = err_q & ~clr_err;

    unique case (state_q)
      ST_IDLE: begin
        if (iv_load) chain_d = iv_data;
        if (in_valid) begin
          enc_d    = cfg_encrypt;
          sa_d     = cfg_sa;
          cbc_d    = cfg_cbc;
          in_reg_d = in_data;
          pdata_d  = (cfg_encrypt && cfg_cbc) ? (in_data ^ chain_src) : in_data;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        cnt_d = cnt_inc;
        if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!block_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (block_ready) begin
          if (cbc_q && !enc_q) begin
            out_data_d = eData ^ chain_q;
            chain_d    = in_reg_q;
          end else begin
            out_data_d = eData;
            if (cbc_q) chain_d = eData;
          end
          state_d = ST_OUT;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    start_d     = (state_d == ST_START);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= ST_IDLE;
      enc_q       <= 1'b0;
      sa_q        <= 1'b0;
      cbc_q       <= 1'b0;
      in_reg_q    <= '0;
      pdata_q     <= '0;
      chain_q     <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      sa_q        <= sa_d;
      cbc_q       <= cbc_d;
      in_reg_q    <= in_reg_d;
      pdata_q     <= pdata_d;
      chain_q     <= chain_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign block_start = start_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign encrypt     = enc_q;
  assign sa          = sa_q;
  assign pData       = pdata_q;
  assign out_data    = out_data_q;

endmodule

// File: tb/tb_ibr128_block_ctrl.sv
// Scoreboard bench for ibr128_block_ctrl with a behavioural core model and a second
// instance (short timeout, core never ready) for the abort path.
module tb_ibr128_block_ctrl;
  import ibr128_block_ctrl_pkg::*;

  localparam int CORE_LAT = 20;

  logic   Clk = 1'b0;
  logic   RstN = 1'b1;
  logic   cfg_encrypt = 1'b0, cfg_sa = 1'b0, cfg_cbc = 1'b0;
  logic   iv_load = 1'b0, clr_err = 1'b0;
  logic   in_valid = 1'b0, to_in_valid = 1'b0, out_ready = 1'b1;
  block_t iv_data = '0, in_data = '0;

  logic   in_ready, encrypt, sa, block_start, out_valid, busy, err_timeout;
  block_t pData, out_data;
  logic   core_ready;
  block_t core_edata;

  logic   to_in_ready, to_encrypt, to_sa, to_block_start, to_out_valid, to_busy, to_err;
  block_t to_pdata, to_out_data;

  always #5 Clk = ~Clk;

  ibr128_block_ctrl u_dut (
    .Clk(Clk), .RstN(RstN), .cfg_encrypt(cfg_encrypt), .cfg_sa(cfg_sa), .cfg_cbc(cfg_cbc),
    .iv_load(iv_load), .iv_data(iv_data), .clr_err(clr_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .encrypt(encrypt), .sa(sa),
    .block_start(block_start), .pData(pData), .block_ready(core_ready), .eData(core_edata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .err_timeout(err_timeout)
  );

  ibr128_block_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) u_to (
    .Clk(Clk), .RstN(RstN), .cfg_encrypt(cfg_encrypt), .cfg_sa(cfg_sa), .cfg_cbc(cfg_cbc),
    .iv_load(iv_load), .iv_data(iv_data), .clr_err(clr_err), .in_valid(to_in_valid),
    .in_ready(to_in_ready), .in_data(in_data), .encrypt(to_encrypt), .sa(to_sa),
    .block_start(to_block_start), .pData(to_pdata), .block_ready(1'b0), .eData(128'h0),
    .out_valid(to_out_valid), .out_ready(1'b1), .out_data(to_out_data), .busy(to_busy),
    .err_timeout(to_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic block_t core_fn(block_t p, logic enc, logic s);
    block_t k_enc, k_dec, k_sa;
    k_enc = {4{32'h9E3779B9}};
    k_dec = {4{32'h7F4A7C15}};
    k_sa  = {2{64'h0F0FF0F03C3CC3C3}};
    return {p[119:0], p[127:120]} ^ (enc ? k_enc : k_dec) ^ (s ? k_sa : '0);
  endfunction

  // Core model: result CORE_LAT+1 edges after block_start is seen; ready is a held level.
  int     stale_cycles = 0;
  int     core_cnt, stale_cnt;
  block_t core_pend;
  always @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      core_ready <= 1'b0;
      core_edata <= '0;
      core_pend  <= '0;
      core_cnt   <= 0;
      stale_cnt  <= 0;
    end else if (block_start) begin
      core_pend <= core_fn(pData, encrypt, sa);
      core_cnt  <= CORE_LAT + 1;
      if (stale_cycles == 0) core_ready <= 1'b0;
      else stale_cnt <= stale_cycles;
    end else begin
      if (stale_cnt != 0) begin
        stale_cnt <= stale_cnt - 1;
        if (stale_cnt == 1) core_ready <= 1'b0;
      end
      if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          core_ready <= 1'b1;
          core_edata <= core_pend;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc++;

  block_t exp_pd_q[$];
  block_t exp_out_q[$];
  block_t m_chain = '0;
  int     accept_cyc = 0;
  int     bs_count = 0;
  bit     lat_check_en = 1'b0;
  bit     ov_prev = 1'b0;
  bit     to_ov_seen = 1'b0;

  always @(negedge Clk) begin
    if (RstN) begin
      if (block_start) begin
        bs_count++;
        if (exp_pd_q.size() == 0) check("bs_extra", 128'(exp_pd_q.size()), 128'd1);
        else check("pData", pData, exp_pd_q.pop_front());
      end
      if (out_valid && !ov_prev && lat_check_en) begin
        check("latency", 128'(cyc - accept_cyc), 128'(3 + CORE_LAT));
        lat_check_en = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) check("ov_extra", 128'(exp_out_q.size()), 128'd1);
        else check("out_data", out_data, exp_out_q.pop_front());
      end
      ov_prev = out_valid;
      if (to_out_valid) to_ov_seen = 1'b1;
    end
  end

  task automatic send_block(input block_t d, input logic enc, input logic s, input logic c,
                            input logic with_iv, input block_t iv);
    int     n;
    block_t ch, pd, e, o;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!in_ready) check("accept_wait", 128'(in_ready), 128'd1);
    ch = with_iv ? iv : m_chain;
    pd = (enc && c) ? (d ^ ch) : d;
    e  = core_fn(pd, enc, s);
    o  = (!enc && c) ? (e ^ ch) : e;
    m_chain = ch;
    if (c) m_chain = enc ? e : d;
    exp_pd_q.push_back(pd);
    exp_out_q.push_back(o);
    cfg_encrypt = enc; cfg_sa = s; cfg_cbc = c;
    in_data = d; iv_load = with_iv; iv_data = iv; in_valid = 1'b1;
    @(posedge Clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0; iv_load = 1'b0;
  endtask

  task automatic load_iv(input block_t iv);
    iv_data = iv; iv_load = 1'b1;
    @(posedge Clk); #1;
    iv_load = 1'b0;
    m_chain = iv;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_out_q.size() != 0 || !in_ready) && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    check("drain", 128'(exp_out_q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs_before, n;
    #2 RstN = 1'b0;
    #10;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_block_start", 128'(block_start), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err_timeout), 128'd0);
    check("rst_pdata", pData, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_enc_sa", 128'({encrypt, sa}), 128'd0);
    @(negedge Clk) RstN = 1'b1;
    @(posedge Clk); #1;

    // ECB encrypt, latency and single start pulse
    bs_before = bs_count;
    lat_check_en = 1'b1;
    send_block(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drain(200);
    check("bs_pulses", 128'(bs_count - bs_before), 128'd1);
    check("lat_seen", 128'(lat_check_en), 128'd0);

    // ECB decrypt sa=1; cfg changes mid-operation must not leak through
    send_block(128'hDEADBEEF_00112233_44556677_8899AABB, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cfg_encrypt = 1'b1; cfg_sa = 1'b0; cfg_cbc = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("enc_held", 128'(encrypt), 128'd0);
    check("sa_held", 128'(sa), 128'd1);
    check("busy_mid", 128'(busy), 128'd1);
    check("in_ready_mid", 128'(in_ready), 128'd0);
    drain(200);

    // CBC encrypt, IV = 1
    load_iv(128'h1);
    send_block(128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    send_block(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain(200);

    // CBC decrypt, IV = FF loaded on the accept cycle; mid-op IV load ignored
    send_block(128'h11111111_22222222_33333333_44444444, 1'b0, 1'b0, 1'b1, 1'b1, 128'hFF);
    send_block(128'h55555555_66666666_77777777_88888888, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (5) @(posedge Clk);
    #1;
    iv_data = 128'hBAD0BAD0; iv_load = 1'b1;
    @(posedge Clk); #1;
    iv_load = 1'b0;
    drain(200);
    send_block(128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain(200);

    // Stale block_ready held across START
    stale_cycles = 5;
    send_block(128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drain(200);
    stale_cycles = 0;

    // Output backpressure
    out_ready = 1'b0;
    send_block(128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("bp_valid", 128'(out_valid), 128'd1);
    repeat (10) begin
      @(posedge Clk); #1;
      check("bp_data", out_data, exp_out_q[0]);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    drain(200);

    // Reset in WAIT drops the block and clears the chain
    send_block(128'h89ABCDEF_01234567_89ABCDEF_01234567, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (8) @(posedge Clk);
    #1;
    check("pre_rst_busy", 128'(busy), 128'd1);
    RstN = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_pdata", pData, 128'd0);
    exp_pd_q.delete();
    exp_out_q.delete();
    m_chain = '0;
    @(negedge Clk) RstN = 1'b1;
    @(posedge Clk); #1;
    send_block(128'h76543210_FEDCBA98_76543210_FEDCBA98, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain(200);

    // Timeout on the short-timeout instance
    to_in_valid = 1'b1;
    @(posedge Clk); #1;
    to_in_valid = 1'b0;
    repeat (16) @(posedge Clk);
    #1;
    check("to_err_early", 128'(to_err), 128'd0);
    check("to_busy", 128'(to_busy), 128'd1);
    @(posedge Clk); #1;
    check("to_err", 128'(to_err), 128'd1);
    check("to_in_ready", 128'(to_in_ready), 128'd1);
    check("to_busy_done", 128'(to_busy), 128'd0);
    clr_err = 1'b1;
    @(posedge Clk); #1;
    clr_err = 1'b0;
    check("to_clr", 128'(to_err), 128'd0);
    to_in_valid = 1'b1;
    @(posedge Clk); #1;
    to_in_valid = 1'b0;
    repeat (16) @(posedge Clk);
    #1;
    clr_err = 1'b1;
    @(posedge Clk); #1;
    clr_err = 1'b0;
    check("to_clr_vs_timeout", 128'(to_err), 128'd1);
    check("to_no_out", 128'(to_ov_seen), 128'd0);

    check("pd_left", 128'(exp_pd_q.size()), 128'd0);
    check("main_err", 128'(err_timeout), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
